// File: rtl/dvp_pkg.sv
// Shared types and constants for the RGB565-to-DVP sensor emulator.
package dvp_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    VSYNC,
    VBP,
    ACTIVE,
    VFP
  } dvp_state_e;

  localparam int R_MSB = 15;
  localparam int R_LSB = 11;
  localparam int G_MSB = 10;
  localparam int G_LSB = 5;
  localparam int B_MSB = 4;
  localparam int B_LSB = 0;

endpackage

// File: rtl/dvp_timing_cnt.sv
// Horizontal byte counter and per-state line counter with a state-end strobe.
module dvp_timing_cnt
  import dvp_pkg::*;
#(
  parameter logic [CNT_W-1:0] LINE_LEN = 16'd1664
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [CNT_W-1:0] lines,
  output logic [CNT_W-1:0] hcnt_nxt,
  output logic             state_end
);

  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] vcnt;
  logic             line_end;

  assign line_end  = run && (hcnt == LINE_LEN - 1'b1);
  assign state_end = line_end && (vcnt == lines - 1'b1);
  // Every state spans whole lines, so a state change always lands on hcnt=0.
  assign hcnt_nxt  = (!run || line_end) ? '0 : hcnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      hcnt <= '0;
      vcnt <= '0;
    end else begin
      hcnt <= hcnt_nxt;
      if (state_end)
        vcnt <= '0;
      else if (line_end)
        vcnt <= vcnt + 1'b1;
    end
  end

endmodule

// File: rtl/dvp_rgb565_tx.sv
// Serialises RGB565 pixels onto an 8-bit DVP bus with self-generated frame timing.
//   state  | meaning
//   IDLE   | bus quiet, waiting for enable
//   VSYNC  | vsync high for V_SYNC lines
//   VBP    | blank lines after vsync
//   ACTIVE | V_ACTIVE lines of 2*H_ACTIVE bytes then H_BLANK idle cycles
//   VFP    | blank lines after the last active line; frame_done on the final cycle
module dvp_rgb565_tx
  import dvp_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned H_BLANK  = 64,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BPORCH = 8,
  parameter int unsigned V_FPORCH = 4,
  parameter logic [15:0] FILL     = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        pix_valid,
  input  logic [15:0] pix_data,
  input  logic        pix_sof,
  output logic        pix_ready,
  output logic        dvp_vsync,
  output logic        dvp_href,
  output logic [7:0]  dvp_data,
  output logic        frame_done,
  output logic        underflow,
  output logic        sof_err,
  output logic        busy
);

  localparam logic [CNT_W-1:0] ACT_BYTES = CNT_W'(2 * H_ACTIVE);
  localparam logic [CNT_W-1:0] LINE_LEN  = CNT_W'(2 * H_ACTIVE + H_BLANK);
  localparam dvp_state_e AFTER_SYNC = (V_BPORCH != 0) ? VBP : ACTIVE;
  localparam dvp_state_e FIRST_ST   = (V_SYNC != 0) ? VSYNC : AFTER_SYNC;

  dvp_state_e       state, state_nxt;
  logic             frame_start, frame_end;
  logic [CNT_W-1:0] lines;
  logic [CNT_W-1:0] hcnt_nxt;
  logic             state_end;
  logic             href_nxt;
  logic             accept;
  logic             first_pix, first_now;
  logic [15:0]      fetch;
  logic [7:0]       hold_lo;

  dvp_timing_cnt #(.LINE_LEN(LINE_LEN)) u_timing (
    .clk       (clk),
    .rst       (rst),
    .run       (state != IDLE),
    .lines     (lines),
    .hcnt_nxt  (hcnt_nxt),
    .state_end (state_end)
  );

  always_comb begin
    lines = 16'd1;
    case (state)
      VSYNC:   lines = CNT_W'(V_SYNC);
      VBP:     lines = CNT_W'(V_BPORCH);
      ACTIVE:  lines = CNT_W'(V_ACTIVE);
      VFP:     lines = CNT_W'(V_FPORCH);
      default: lines = 16'd1;
    endcase
  end

  always_comb begin
    state_nxt = state;
    frame_end = 1'b0;
    case (state)
      IDLE:    if (enable) state_nxt = FIRST_ST;
      VSYNC:   if (state_end) state_nxt = AFTER_SYNC;
      VBP:     if (state_end) state_nxt = ACTIVE;
      ACTIVE:  if (state_end) begin
                 if (V_FPORCH != 0) state_nxt = VFP;
                 else               frame_end = 1'b1;
               end
      VFP:     if (state_end) frame_end = 1'b1;
      default: state_nxt = IDLE;
    endcase
    if (frame_end)
      state_nxt = enable ? FIRST_ST : IDLE;
    frame_start = enable && ((state == IDLE) || frame_end);
    if (rst) begin
      state_nxt   = IDLE;
      frame_start = 1'b0;
      frame_end   = 1'b0;
    end
  end

  // Outputs are registered from next-cycle timing so an accepted pixel's high byte appears one cycle later.
  assign href_nxt   = (state_nxt == ACTIVE) && (hcnt_nxt < ACT_BYTES);
  assign pix_ready  = href_nxt && !hcnt_nxt[0];
  assign accept     = pix_ready && pix_valid;
  assign fetch      = pix_valid ? pix_data : FILL;
  assign first_now  = frame_start || first_pix;
  assign frame_done = frame_end;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dvp_vsync <= 1'b0;
      dvp_href  <= 1'b0;
      dvp_data  <= 8'h00;
      hold_lo   <= 8'h00;
      first_pix <= 1'b0;
      underflow <= 1'b0;
      sof_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      dvp_vsync <= (state_nxt == VSYNC);
      dvp_href  <= href_nxt;
      if (!href_nxt)
        dvp_data <= 8'h00;
      else if (hcnt_nxt[0])
        dvp_data <= hold_lo;
      else
        dvp_data <= fetch[15:8];
      if (pix_ready)
        hold_lo <= fetch[7:0];
      first_pix <= accept ? 1'b0 : first_now;
      underflow <= (underflow && !frame_start) || (pix_ready && !pix_valid);
      sof_err   <= (sof_err && !frame_start) ||
                   (accept && (first_now ? !pix_sof : pix_sof));
    end
  end

endmodule

// File: tb/tb_dvp_rgb565_tx.sv
// Scoreboard bench for dvp_rgb565_tx with a 4x2 active window (11-cycle lines, 55-cycle frames).
module tb_dvp_rgb565_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        pix_valid = 1'b0;
  logic [15:0] pix_data = 16'h0000;
  logic        pix_sof = 1'b0;
  logic        pix_ready, dvp_vsync, dvp_href, frame_done, underflow, sof_err, busy;
  logic [7:0]  dvp_data;

  always #5 clk = ~clk;

  dvp_rgb565_tx #(
    .H_ACTIVE(4), .V_ACTIVE(2), .H_BLANK(3),
    .V_SYNC(1), .V_BPORCH(1), .V_FPORCH(1), .FILL(16'h0000)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_sof(pix_sof),
    .pix_ready(pix_ready), .dvp_vsync(dvp_vsync), .dvp_href(dvp_href),
    .dvp_data(dvp_data), .frame_done(frame_done), .underflow(underflow),
    .sof_err(sof_err), .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];

  int fc = -1;
  int frm = -1;
  int fpx = 0;
  int gidx = 0;
  int rdy_cnt = 0;
  bit uf_m = 0, sof_m = 0, first_m = 0;
  bit pend_uf = 0, pend_sof = 0;

  // per-frame stimulus: pixel index sent invalid (-1 none); sof mode 0 correct, 1 none, 2 on pixel 1
  int drop_tab [7] = '{-1, 2, -1, -1, -1, -1, -1};
  int sof_tab  [7] = '{0, 0, 1, 2, 0, 0, 0};

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h frame=%0d fc=%0d", tag, act, exp, frm, fc);
    end
  endtask

  function automatic bit exp_href(input int f);
    if (f < 22 || f > 43) return 1'b0;
    return ((f - 22) % 11) < 8;
  endfunction

  function automatic bit exp_ready(input int f);
    int h;
    if (f == 21) return 1'b1;
    if (f < 22 || f > 43) return 1'b0;
    h = (f - 22) % 11;
    return ((h % 2 == 1) && (h < 7)) || ((h == 10) && (f < 33));
  endfunction

  task automatic tick();
    bit starting, v, s;
    logic [15:0] pv, px;
    @(posedge clk);
    starting = 1'b0;
    if (rst) begin
      fc = -1; uf_m = 1'b0; sof_m = 1'b0;
      sb.delete();
    end else begin
      if (fc < 0) begin
        if (enable) begin fc = 0; starting = 1'b1; end
      end else if (fc == 54) begin
        if (enable) begin fc = 0; starting = 1'b1; end
        else fc = -1;
      end else begin
        fc++;
      end
      uf_m  = (starting ? 1'b0 : uf_m) | pend_uf;
      sof_m = (starting ? 1'b0 : sof_m) | pend_sof;
      if (starting) begin
        first_m = 1'b1; fpx = 0; frm++; rdy_cnt = 0;
      end
    end
    pend_uf = 1'b0;
    pend_sof = 1'b0;

    @(negedge clk);
    chk("vsync", 32'(dvp_vsync), 32'(fc >= 0 && fc <= 10));
    chk("href", 32'(dvp_href), 32'(exp_href(fc)));
    chk("ready", 32'(pix_ready), 32'(exp_ready(fc)));
    chk("frame_done", 32'(frame_done), 32'(fc == 54));
    chk("busy", 32'(busy), 32'(fc >= 0));
    chk("underflow", 32'(underflow), 32'(uf_m));
    chk("sof_err", 32'(sof_err), 32'(sof_m));
    if (dvp_href) begin
      chk("byte_avail", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) chk("byte", 32'(dvp_data), 32'(sb.pop_front()));
    end else begin
      chk("data_idle", 32'(dvp_data), 32'd0);
    end
    if (fc >= 0 && pix_ready) rdy_cnt++;
    if (fc == 54) chk("ready_count", 32'(rdy_cnt), 32'd8);

    if (exp_ready(fc) && frm >= 0 && frm < 7) begin
      v  = (fpx != drop_tab[frm]);
      s  = (sof_tab[frm] == 0) ? (fpx == 0) : (sof_tab[frm] == 2) ? (fpx == 1) : 1'b0;
      pv = 16'h1234 + 16'(gidx) * 16'h4444;
      pix_valid = v;
      pix_sof   = s;
      pix_data  = v ? pv : 16'($urandom);
      px = v ? pv : 16'h0000;
      sb.push_back(px[15:8]);
      sb.push_back(px[7:0]);
      if (v) begin
        pend_sof = first_m ? !s : s;
        first_m  = 1'b0;
      end else begin
        pend_uf = 1'b1;
      end
      fpx++;
      gidx++;
    end else begin
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
      pix_data  = 16'h0000;
    end
  endtask

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();

    // frames 0..4 back to back; enable dropped inside frame 4
    enable = 1'b1;
    for (int i = 0; i < 400 && !(frm == 4 && fc == 30); i++) tick();
    chk("reach_f4", 32'(frm == 4 && fc == 30), 32'd1);
    enable = 1'b0;
    for (int i = 0; i < 100 && fc != -1; i++) tick();
    chk("idle_after_f4", 32'(fc), 32'hffff_ffff);
    repeat (3) tick();

    // frame 5 is cut by reset mid-ACTIVE, frame 6 restarts cleanly
    enable = 1'b1;
    for (int i = 0; i < 100 && !(frm == 5 && fc == 25); i++) tick();
    chk("reach_f5", 32'(frm == 5 && fc == 25), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 100 && !(frm == 6 && fc == 30); i++) tick();
    chk("reach_f6", 32'(frm == 6 && fc == 30), 32'd1);
    enable = 1'b0;
    for (int i = 0; i < 100 && fc != -1; i++) tick();
    chk("idle_after_f6", 32'(fc), 32'hffff_ffff);
    repeat (3) tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
